// File: rtl/mem_dump_sequencer.sv
// Batch readback sequencer: walks a wrapping range of result-memory entries and, for each one,
// reads it, samples it into the serial transceiver and transmits it before moving on.
module mem_dump_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] baseAddr,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic                  abort,
    input  logic                  txDone,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memValid,
    output logic                  memRW,
    output logic                  sampleData,
    output logic                  txData,
    output logic                  memMode,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_WIDTH:0]   xferCnt
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StSample,
        StTx,
        StWaitDone,
        StDone
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   OneLeft  = (ADDR_WIDTH + 1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [ADDR_WIDTH:0]   xfer_q, xfer_d;
    logic                  pend_q, pend_d;
    logic                  aborted_q, aborted_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            xfer_q      <= '0;
            pend_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            xfer_q      <= xfer_d;
            pend_q      <= pend_d;
            aborted_q   <= aborted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        xfer_d      = xfer_q;
        pend_d      = pend_q;
        aborted_d   = aborted_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d      = baseAddr;
                    remaining_d = count;
                    xfer_d      = '0;
                    pend_d      = 1'b0;
                    aborted_d   = 1'b0;
                    state_d     = (count == '0) ? StDone : StRead;
                end
            end
            // Before the transmission starts an abort drops the entry outright.
            StRead, StWait, StSample: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    state_d = (state_q == StRead) ? StWait :
                              (state_q == StWait) ? StSample : StTx;
                end
            end
            StTx: begin
                pend_d  = pend_q | abort;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                pend_d = pend_q | abort;
                if (txDone) begin
                    xfer_d      = xfer_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == OneLeft || pend_d) begin
                        aborted_d = pend_d;
                        state_d   = StDone;
                    end else begin
                        addr_d  = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
                        state_d = StRead;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign memAddr    = addr_q;
    assign memValid   = (state_q == StRead);
    assign memRW      = 1'b0;
    assign sampleData = (state_q == StSample);
    assign txData     = (state_q == StTx);
    assign busy       = (state_q != StIdle);
    assign memMode    = busy;
    assign done       = (state_q == StDone);
    assign aborted    = aborted_q;
    assign xferCnt    = xfer_q;

endmodule

// File: tb/tb_mem_dump_sequencer.sv
// Scoreboard bench for mem_dump_sequencer: the driver pushes expected reads, samples, transmits
// and completions; an independent monitor pops and compares them as the DUT strobes.
module tb_mem_dump_sequencer;

    localparam int AW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset, start, abort, txDone;
    logic [AW-1:0] baseAddr;
    logic [AW:0]   count;
    logic [AW-1:0] memAddr;
    logic          memValid, memRW, sampleData, txData, memMode, busy, done, aborted;
    logic [AW:0]   xferCnt;

    int n_checks = 0;
    int n_errors = 0;

    int exp_rd[$];
    int exp_sm[$];
    int exp_tx[$];
    int exp_done_x[$];
    int exp_done_a[$];

    mem_dump_sequencer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr), .count(count),
        .abort(abort), .txDone(txDone), .memAddr(memAddr), .memValid(memValid), .memRW(memRW),
        .sampleData(sampleData), .txData(txData), .memMode(memMode), .busy(busy), .done(done),
        .aborted(aborted), .xferCnt(xferCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_memAddr"}, int'(memAddr), 0);
        chk({tag, "_xferCnt"}, int'(xferCnt), 0);
        chk({tag, "_strobes"}, int'({memValid, sampleData, txData, done}), 0);
        chk({tag, "_busy_mode"}, int'({busy, memMode}), 0);
        chk({tag, "_aborted"}, int'(aborted), 0);
    endtask

    // akind: 0 none, 1 abort in WAIT of entry aidx, 2 abort in WAIT_DONE of entry aidx.
    // rst_idx >= 0 resets the DUT during WAIT_DONE of that entry.
    task automatic run_dump(input int base, input int cnt, input int akind, input int aidx,
                            input bit extra_start, input int rst_idx, input int delay);
        int  addr;
        bit  last;
        bit  late;
        int  exp_ab;
        exp_ab = 0;
        if (cnt == 0) begin
            exp_done_x.push_back(0);
            exp_done_a.push_back(0);
        end
        baseAddr = AW'(base);
        count    = (AW + 1)'(cnt);
        start    = 1'b1;
        step();
        start    = 1'b0;
        baseAddr = AW'($urandom_range(0, 255));
        count    = (AW + 1)'($urandom_range(0, 511));
        if (cnt == 0) begin
            chk("zero_done", int'(done), 1);
            chk("zero_busy", int'(busy), 1);
        end
        for (int i = 0; i < cnt; i++) begin
            addr = (base + i) % DEPTH;
            exp_rd.push_back(addr);
            if (akind == 1 && i == aidx) begin
                exp_done_x.push_back(i);
                exp_done_a.push_back(1);
                exp_ab = 1;
                step();
                abort = 1'b1;
                step();
                abort = 1'b0;
                break;
            end
            exp_sm.push_back(addr);
            exp_tx.push_back(addr);
            repeat (4) step();
            if (rst_idx == i) begin
                step();
                #2 reset = 1'b1;
                #1 chk_reset_outputs("mid_reset");
                @(negedge clk);
                reset = 1'b0;
                step();
                chk("post_reset_idle", int'(busy), 0);
                return;
            end
            if (extra_start) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end
            late = (akind == 2 && i == aidx);
            if (late) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
            end
            repeat (delay) step();
            last = (i == cnt - 1) || late;
            if (last) begin
                exp_done_x.push_back(i + 1);
                exp_done_a.push_back(int'(late));
                exp_ab = int'(late);
            end
            txDone = 1'b1;
            step();
            txDone = 1'b0;
            if (last) break;
        end
        step();
        chk("idle_after_done", int'(busy), 0);
        chk("aborted_held", int'(aborted), exp_ab);
    endtask

    initial begin : monitor
        int cyc;
        int last_rd;
        cyc     = 0;
        last_rd = -100;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (memValid | sampleData | txData | done) begin
                    chk("strobe_excl", $countones({memValid, sampleData, txData, done}), 1);
                    chk("memMode_busy", int'({memMode, busy}), 3);
                end
                if (memValid) begin
                    chk("memRW_read", int'(memRW), 0);
                    last_rd = cyc;
                    if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                    else chk("rd_addr", int'(memAddr), exp_rd.pop_front());
                end
                if (sampleData) begin
                    if (exp_sm.size() == 0) chk("sample_unexpected", 1, 0);
                    else chk("sample_addr", int'(memAddr), exp_sm.pop_front());
                end
                if (txData) begin
                    chk("tx_gap", cyc - last_rd, 3);
                    if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
                    else chk("tx_addr", int'(memAddr), exp_tx.pop_front());
                end
                if (done) begin
                    if (exp_done_x.size() == 0) chk("done_unexpected", 1, 0);
                    else begin
                        chk("done_xferCnt", int'(xferCnt), exp_done_x.pop_front());
                        chk("done_aborted", int'(aborted), exp_done_a.pop_front());
                    end
                end
            end
        end
    end

    initial begin : driver
        int cnt;
        int kind;
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        txDone   = 1'b0;
        baseAddr = '0;
        count    = '0;
        #23;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("idle_after_reset", int'(busy), 0);

        run_dump(2, 3, 0, 0, 1'b0, -1, 9);   // basic
        run_dump(6, 4, 0, 0, 1'b0, -1, 2);   // wrap
        run_dump(3, 0, 0, 0, 1'b0, -1, 0);   // count = 0
        run_dump(1, 2, 0, 0, 1'b1, -1, 1);   // start while busy
        run_dump(4, 5, 1, 0, 1'b0, -1, 1);   // early abort
        run_dump(5, 5, 2, 1, 1'b0, -1, 3);   // late abort
        run_dump(2, 5, 0, 0, 1'b0, 1, 0);    // reset mid-dump
        run_dump(0, 10, 0, 0, 1'b0, -1, 0);  // count > DEPTH

        for (int n = 0; n < 25; n++) begin
            cnt  = $urandom_range(0, 12);
            kind = (cnt == 0) ? 0 : $urandom_range(0, 2);
            run_dump($urandom_range(0, DEPTH - 1), cnt, kind,
                     (cnt == 0) ? 0 : $urandom_range(0, cnt - 1),
                     1'($urandom_range(0, 1)), -1, $urandom_range(0, 5));
            repeat ($urandom_range(0, 3)) step();
        end

        repeat (5) step();
        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("sample_queue_empty", exp_sm.size(), 0);
        chk("tx_queue_empty", exp_tx.size(), 0);
        chk("done_queue_empty", exp_done_x.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
